// File: rtl/daio_rx_buffer_ctrl_if.sv
// Host-side read and status bus of the DAIO receive buffer controller.
// The controller drives the slave modport; the host drives the master modport.
interface daio_rx_buffer_ctrl_if #(
  parameter int DATA_W = 20
);
  logic              host_req;
  logic [2:0]        host_addr;
  logic              status_clr;
  logic [DATA_W:0]   host_rdata;
  logic              host_ack;
  logic              irq;
  logic [2:0]        status;

  modport master (
    output host_req,
    output host_addr,
    output status_clr,
    input  host_rdata,
    input  host_ack,
    input  irq,
    input  status
  );

  modport slave (
    input  host_req,
    input  host_addr,
    input  status_clr,
    output host_rdata,
    output host_ack,
    output irq,
    output status
  );
endinterface

// File: rtl/daio_rx_buffer_ctrl.sv
// DAIO receive buffer controller: captures A/B subframes into a bank, moves the bank to a host buffer.
// Optional feature macro: DAIO_RX_PARITY_CHECK_EN (stores parity flag and reports parity errors).
module daio_rx_buffer_ctrl #(
  parameter int DATA_W = 20,
  parameter int FRAMES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_enable,
  input  logic              load_A,
  input  logic              load_B,
  input  logic              load_buff,
  input  logic [DATA_W-1:0] shift_reg,
  input  logic              parity,
  input  logic [1:0]        frame_ofs,
  daio_rx_buffer_ctrl_if.slave host
);

  localparam int DEPTH = 2 * FRAMES;

  typedef logic [DATA_W:0] entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT
  } read_state_t;

  entry_t           bank   [DEPTH];
  entry_t           buffer [DEPTH];
  logic             prev_a;
  logic             prev_b;
  logic             prev_buff;
  logic [DEPTH-1:0] valid_mask;
  logic             buf_valid;
  logic [2:0]       status_q;
  read_state_t      state;
  logic [2:0]       addr_q;
  entry_t           rdata_q;
  logic             ack_q;

  logic             ev_a;
  logic             ev_b;
  logic             ev_buff;
  logic             cap_a;
  logic             cap_b;
  logic [2:0]       idx_a;
  logic [2:0]       idx_b;
  logic             par_bit;
  entry_t           word;
  logic             par_hit;
  logic             release_buf;
  logic             held;
  logic             do_transfer;
  logic [DEPTH-1:0] cap_bits;
  logic [DEPTH-1:0] mask_next;
  logic [2:0]       status_set;

`ifdef DAIO_RX_PARITY_CHECK_EN
  assign par_bit = parity;
`else
  logic unused_parity;
  assign unused_parity = parity;
  assign par_bit       = 1'b0;
`endif

  assign ev_a    = load_A & ~prev_a;
  assign ev_b    = load_B & ~prev_b;
  assign ev_buff = load_buff & ~prev_buff;
  assign cap_a   = ev_a & rx_enable;
  assign cap_b   = ev_b & rx_enable;
  assign idx_a   = {frame_ofs, 1'b0};
  assign idx_b   = {frame_ofs, 1'b1};
  assign word    = {par_bit, shift_reg};
  assign par_hit = (cap_a | cap_b) & par_bit;

  // A release ack in the same cycle as a transfer frees the buffer first.
  assign release_buf = (state == ACK) && (addr_q == 3'd7) && buf_valid;
  assign held        = buf_valid & ~release_buf;
  assign do_transfer = ev_buff & ~held;

  always_comb begin
    cap_bits = '0;
    if (cap_a) cap_bits[idx_a] = 1'b1;
    if (cap_b) cap_bits[idx_b] = 1'b1;
  end

  // Captures landing with a transfer count toward the next buffer's mask.
  always_comb begin
    mask_next = '0;
    if (rx_enable) begin
      mask_next = (ev_buff ? '0 : valid_mask) | cap_bits;
    end
  end

  always_comb begin
    status_set    = 3'b000;
    status_set[0] = ev_buff & held;
    status_set[1] = par_hit;
    status_set[2] = ev_buff & (valid_mask != '1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_a     <= 1'b0;
      prev_b     <= 1'b0;
      prev_buff  <= 1'b0;
      valid_mask <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
    end else begin
      prev_a     <= load_A;
      prev_b     <= load_B;
      prev_buff  <= load_buff;
      valid_mask <= mask_next;
      if (cap_a) bank[idx_a] <= word;
      if (cap_b) bank[idx_b] <= word;
    end
  end

  // Sticky status: a set condition overrides a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid <= 1'b0;
      status_q  <= 3'b000;
      for (int i = 0; i < DEPTH; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      if (do_transfer) begin
        buf_valid <= 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          buffer[i] <= bank[i];
        end
      end else if (release_buf) begin
        buf_valid <= 1'b0;
      end
      status_q <= (status_q & ~{3{host.status_clr}}) | status_set;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= 3'd0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= 1'b0;
          if (host.host_req) begin
            addr_q  <= host.host_addr;
            rdata_q <= buffer[host.host_addr];
            ack_q   <= 1'b1;
            state   <= ACK;
          end
        end
        ACK: begin
          ack_q <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          ack_q <= 1'b0;
          if (!host.host_req) state <= IDLE;
        end
        default: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign host.host_rdata = rdata_q;
  assign host.host_ack   = ack_q;
  assign host.irq        = buf_valid;
  assign host.status     = status_q;

endmodule

// File: tb/tb_daio_rx_buffer_ctrl.sv
// Scoreboard bench for daio_rx_buffer_ctrl against a frame-level reference model.
module tb_daio_rx_buffer_ctrl;

  localparam int DATA_W = 20;
`ifdef DAIO_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_enable;
  logic        load_A;
  logic        load_B;
  logic        load_buff;
  logic [19:0] shift_reg;
  logic        parity;
  logic [1:0]  frame_ofs;

  int checks = 0;
  int passes = 0;

  logic [20:0] exp_q[$];
  logic [20:0] mon_exp;

  // reference model state
  logic [20:0] bank_m   [8];
  logic [20:0] buffer_m [8];
  logic [7:0]  mask_m;
  logic        bv_m;
  logic [2:0]  st_m;
  logic        pa_m, pb_m, pf_m;

  daio_rx_buffer_ctrl_if #(.DATA_W(DATA_W)) bus();

  daio_rx_buffer_ctrl #(.DATA_W(DATA_W), .FRAMES(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_enable (rx_enable),
    .load_A    (load_A),
    .load_B    (load_B),
    .load_buff (load_buff),
    .shift_reg (shift_reg),
    .parity    (parity),
    .frame_ofs (frame_ofs),
    .host      (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Monitor: every ack is matched against the oldest outstanding expected read.
  always @(negedge clock) begin
    if (bus.host_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL rdata_unexpected: got ack with 0x%0h, expected no ack", bus.host_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("rdata", 32'(bus.host_rdata), 32'(mon_exp));
      end
    end
  end

  // Frame-level model of what the next clock edge does with the current inputs.
  task automatic modelEdge(input bit ack_now, input logic [2:0] ack_addr);
    bit          ev_a, ev_b, ev_f, rel, held;
    logic [2:0]  sets;
    logic [20:0] word;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        bank_m[i]   = '0;
        buffer_m[i] = '0;
      end
      mask_m = '0; bv_m = 1'b0; st_m = '0;
      pa_m = 1'b0; pb_m = 1'b0; pf_m = 1'b0;
      return;
    end
    ev_a = load_A && !pa_m;
    ev_b = load_B && !pb_m;
    ev_f = load_buff && !pf_m;
    sets = '0;
    rel  = ack_now && (ack_addr == 3'd7) && bv_m;
    held = bv_m && !rel;
    if (rel) bv_m = 1'b0;
    if (ev_f) begin
      if (held) sets[0] = 1'b1;
      else begin
        for (int i = 0; i < 8; i++) buffer_m[i] = bank_m[i];
        bv_m = 1'b1;
      end
      if (mask_m != 8'hFF) sets[2] = 1'b1;
      mask_m = '0;
    end
    word = {(PAR_EN ? parity : 1'b0), shift_reg};
    if (rx_enable) begin
      if (ev_a) begin
        bank_m[{frame_ofs, 1'b0}] = word;
        mask_m[{frame_ofs, 1'b0}] = 1'b1;
        if (PAR_EN && parity) sets[1] = 1'b1;
      end
      if (ev_b) begin
        bank_m[{frame_ofs, 1'b1}] = word;
        mask_m[{frame_ofs, 1'b1}] = 1'b1;
        if (PAR_EN && parity) sets[1] = 1'b1;
      end
    end else begin
      mask_m = '0;
    end
    st_m = (st_m & ~{3{bus.status_clr}}) | sets;
    pa_m = load_A; pb_m = load_B; pf_m = load_buff;
  endtask

  task automatic tick(input bit ack_now, input logic [2:0] ack_addr);
    modelEdge(ack_now, ack_addr);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic la, input logic lb, input logic lbuff,
                               input logic [19:0] data, input logic par, input logic [1:0] fo);
    load_A = la; load_B = lb; load_buff = lbuff;
    shift_reg = data; parity = par; frame_ofs = fo;
    tick(1'b0, 3'd0);
  endtask

  task automatic captureSub(input logic [2:0] idx, input logic [19:0] data, input logic par);
    applyStimulus(~idx[0], idx[0], 1'b0, data, par, idx[2:1]);
    applyStimulus(1'b0, 1'b0, 1'b0, data, 1'b0, idx[2:1]);
  endtask

  task automatic fillBuffer(input logic [19:0] base, input int skip, input int par_idx);
    for (int i = 0; i < 8; i++) begin
      if (i != skip) captureSub(3'(i), base + 20'(i), (i == par_idx));
    end
  endtask

  task automatic pulseBuff();
    applyStimulus(1'b0, 1'b0, 1'b1, shift_reg, 1'b0, frame_ofs);
    checkOutput("irq_after_buff", 32'(bus.irq), 32'(bv_m));
    applyStimulus(1'b0, 1'b0, 1'b0, shift_reg, 1'b0, frame_ofs);
  endtask

  task automatic readAddr(input logic [2:0] a, input bit buff_on_ack);
    bus.host_req = 1'b1;
    bus.host_addr = a;
    exp_q.push_back(buffer_m[a]);
    tick(1'b0, 3'd0);
    checkOutput("ack_latency", 32'(bus.host_ack), 32'd1);
    if (buff_on_ack) load_buff = 1'b1;
    tick(1'b1, a);
    checkOutput("ack_single", 32'(bus.host_ack), 32'd0);
    bus.host_req = 1'b0;
    load_buff = 1'b0;
    tick(1'b0, 3'd0);
  endtask

  task automatic clearStatus();
    bus.status_clr = 1'b1;
    tick(1'b0, 3'd0);
    bus.status_clr = 1'b0;
    checkOutput("status_clr", 32'(bus.status), 32'(st_m));
  endtask

  logic [19:0] first_val;

  initial begin
    reset = 1'b1; rx_enable = 1'b0;
    load_A = 1'b0; load_B = 1'b0; load_buff = 1'b0;
    shift_reg = '0; parity = 1'b0; frame_ofs = '0;
    bus.host_req = 1'b0; bus.host_addr = '0; bus.status_clr = 1'b0;
    @(negedge clock);
    tick(1'b0, 3'd0);
    tick(1'b0, 3'd0);
    checkOutput("reset_rdata", 32'(bus.host_rdata), 32'd0);
    checkOutput("reset_ack", 32'(bus.host_ack), 32'd0);
    checkOutput("reset_irq", 32'(bus.irq), 32'd0);
    checkOutput("reset_status", 32'(bus.status), 32'd0);
    reset = 1'b0;
    rx_enable = 1'b1;
    tick(1'b0, 3'd0);

    $display("[TB] full buffer");
    fillBuffer(20'h0A5A0, -1, -1);
    pulseBuff();
    checkOutput("full_irq", 32'(bus.irq), 32'd1);
    for (int a = 0; a < 8; a++) readAddr(3'(a), 1'b0);
    checkOutput("full_irq_released", 32'(bus.irq), 32'd0);
    checkOutput("full_status", 32'(bus.status), 32'd0);

    $display("[TB] overrun");
    fillBuffer(20'h0A5A0, -1, -1);
    pulseBuff();
    fillBuffer(20'h0B000, -1, -1);
    pulseBuff();
    checkOutput("overrun_flag", 32'(bus.status), 32'b001);
    readAddr(3'd0, 1'b0);
    readAddr(3'd7, 1'b0);
    clearStatus();

    $display("[TB] sync error");
    fillBuffer(20'h0C000, 5, -1);
    pulseBuff();
    checkOutput("sync_flag", 32'(bus.status), 32'b100);
    checkOutput("sync_irq", 32'(bus.irq), 32'd1);
    readAddr(3'd5, 1'b0);
    readAddr(3'd7, 1'b0);
    clearStatus();

    $display("[TB] long pulse");
    first_val = 20'($urandom);
    applyStimulus(1'b1, 1'b0, 1'b0, first_val, 1'b0, 2'd1);
    for (int c = 1; c < 30; c++) applyStimulus(1'b1, 1'b0, 1'b0, 20'($urandom), 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 20'($urandom), 1'b0, 2'd1);
    for (int i = 0; i < 8; i++) if (i != 2) captureSub(3'(i), 20'h01230 + 20'(i), 1'b0);
    pulseBuff();
    checkOutput("long_model_first", 32'(buffer_m[2][19:0]), 32'(first_val));
    readAddr(3'd2, 1'b0);
    readAddr(3'd7, 1'b0);
    checkOutput("long_status", 32'(bus.status), 32'd0);

    $display("[TB] parity");
    fillBuffer(20'h0D000, -1, 3);
    checkOutput("parity_flag", 32'(bus.status[1]), 32'(PAR_EN));
    pulseBuff();
    readAddr(3'd3, 1'b0);
    readAddr(3'd7, 1'b0);
    clearStatus();

    $display("[TB] collision and reset");
    fillBuffer(20'h0E000, -1, -1);
    pulseBuff();
    fillBuffer(20'h0F000, -1, -1);
    readAddr(3'd7, 1'b1);
    checkOutput("collision_no_overrun", 32'(bus.status[0]), 32'd0);
    checkOutput("collision_irq", 32'(bus.irq), 32'd1);
    bus.host_req = 1'b1;
    bus.host_addr = 3'd2;
    exp_q.push_back(buffer_m[2]);
    tick(1'b0, 3'd0);
    tick(1'b1, 3'd2);
    reset = 1'b1;
    tick(1'b0, 3'd0);
    checkOutput("midread_rdata", 32'(bus.host_rdata), 32'd0);
    checkOutput("midread_ack", 32'(bus.host_ack), 32'd0);
    checkOutput("midread_irq", 32'(bus.irq), 32'd0);
    checkOutput("midread_status", 32'(bus.status), 32'd0);
    reset = 1'b0;
    exp_q.push_back(buffer_m[2]);
    tick(1'b0, 3'd0);
    checkOutput("post_reset_ack", 32'(bus.host_ack), 32'd1);
    tick(1'b1, 3'd2);
    bus.host_req = 1'b0;
    tick(1'b0, 3'd0);

    $display("[TB] random traffic");
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0: begin
          rx_enable = ($urandom_range(0, 3) != 0);
          tick(1'b0, 3'd0);
        end
        1, 2, 3, 4, 5: captureSub(3'($urandom_range(0, 7)), 20'($urandom), ($urandom_range(0, 7) == 0));
        6: pulseBuff();
        7, 8: readAddr(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
        default: clearStatus();
      endcase
      checkOutput("rnd_irq", 32'(bus.irq), 32'(bv_m));
      checkOutput("rnd_status", 32'(bus.status), 32'(st_m));
    end

    tick(1'b0, 3'd0);
    tick(1'b0, 3'd0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
